// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD engine.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMP   = 3'd1,
    SUB_A = 3'd2,
    SUB_B = 3'd3,
    DONE  = 3'd4
  } gcd_state_t;

endpackage

// File: rtl/gcd_if.sv
// Operand/result handshake bundle for gcd_core.
// The steps field exists only when GCD_STEPS_EN is defined.
interface gcd_if #(
  parameter int unsigned WIDTH = gcd_pkg::GCD_WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic             zero_flag;

`ifdef GCD_STEPS_EN
  logic [WIDTH-1:0] steps;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, gcd_out, zero_flag, steps
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, gcd_out, zero_flag, steps
  );
`else
  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, gcd_out, zero_flag
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, gcd_out, zero_flag
  );
`endif

endinterface

// File: rtl/gcd_datapath.sv
// Operand registers, magnitude comparator and subtractor for the GCD engine.
// Strobes are mutually exclusive by construction in the controlling FSM.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic             load_c,
  input  logic             sub_a_c,
  input  logic             sub_b_c,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             eq_c,
  output logic             gt_c,
  output logic             a_zero_c,
  output logic             b_zero_c
);

  // Subtraction is only requested when the minuend is strictly larger.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load_c) begin
      a_q <= a_in;
      b_q <= b_in;
    end else if (sub_a_c) begin
      a_q <= a_q - b_q;
    end else if (sub_b_c) begin
      b_q <= b_q - a_q;
    end
  end

  assign eq_c     = (a_q == b_q);
  assign gt_c     = (a_q > b_q);
  assign a_zero_c = (a_q == '0);
  assign b_zero_c = (b_q == '0);

endmodule

// File: rtl/gcd_core.sv
// Euclid (subtractive) GCD engine with valid/ready handshakes on both sides.
// Define GCD_STEPS_EN to add the subtraction counter and the steps output.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF
) (
  input  logic CLK100MHZ,
  input  logic RST,
  gcd_if.slave bus
);

  gcd_state_t       state_q;
  gcd_state_t       state_n;

  logic             load_c;
  logic             sub_a_c;
  logic             sub_b_c;
  logic             done_c;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             eq_c;
  logic             gt_c;
  logic             a_zero_c;
  logic             b_zero_c;
  logic [WIDTH-1:0] res_c;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] gcd_q;
  logic             zero_q;

  gcd_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .CLK100MHZ (CLK100MHZ),
    .RST       (RST),
    .load_c    (load_c),
    .sub_a_c   (sub_a_c),
    .sub_b_c   (sub_b_c),
    .a_in      (bus.a_in),
    .b_in      (bus.b_in),
    .a_q       (a_q),
    .b_q       (b_q),
    .eq_c      (eq_c),
    .gt_c      (gt_c),
    .a_zero_c  (a_zero_c),
    .b_zero_c  (b_zero_c)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and datapath strobes; CMP checks zero operands before equality.
  always_comb begin
    state_n = state_q;
    load_c  = 1'b0;
    sub_a_c = 1'b0;
    sub_b_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load_c  = 1'b1;
          state_n = CMP;
        end
      end
      CMP: begin
        if (a_zero_c || b_zero_c || eq_c) begin
          done_c  = 1'b1;
          state_n = DONE;
        end else if (gt_c) begin
          state_n = SUB_A;
        end else begin
          state_n = SUB_B;
        end
      end
      SUB_A: begin
        sub_a_c = 1'b1;
        state_n = CMP;
      end
      SUB_B: begin
        sub_b_c = 1'b1;
        state_n = CMP;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // With A zero the answer is B, which also covers the both-zero case.
  assign res_c = a_zero_c ? b_q : a_q;

  // Handshake flags follow the next state so they line up with the state register.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      gcd_q       <= '0;
      zero_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_n == IDLE);
      out_valid_q <= (state_n == DONE);
      if (done_c) begin
        gcd_q  <= res_c;
        zero_q <= a_zero_c & b_zero_c;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.gcd_out   = gcd_q;
  assign bus.zero_flag = zero_q;

`ifdef GCD_STEPS_EN
  logic [WIDTH-1:0] step_cnt_q;
  logic [WIDTH-1:0] steps_q;

  // At most 2^WIDTH-2 subtractions, so the counter cannot wrap.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      step_cnt_q <= '0;
      steps_q    <= '0;
    end else begin
      if (load_c) begin
        step_cnt_q <= '0;
      end else if (sub_a_c || sub_b_c) begin
        step_cnt_q <= step_cnt_q + WIDTH'(1);
      end
      if (done_c) begin
        steps_q <= step_cnt_q;
      end
    end
  end

  assign bus.steps = steps_q;
`endif

endmodule

// File: doc/gcd_core.md
# gcd_core

Parametrised Euclid (subtractive) GCD engine with valid/ready handshakes on both sides. It is the next-generation replacement for the fixed 8-bit switch-driven GCD FSM. Operand width is a parameter, zero operands terminate cleanly, and results are held until consumed. It sits between an operand source (switch capture or a CPU-side register) and a result sink such as the seven-segment display driver.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `CLK100MHZ`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  engine can accept operands; high only in IDLE.
- `a_in`  in  WIDTH  operand A.
- `b_in`  in  WIDTH  operand B.
- `out_valid`  out  1  result held valid; high only in DONE.
- `out_ready`  in  1  sink accepts the result.
- `gcd_out`  out  WIDTH  result, unsigned.
- `zero_flag`  out  1  both operands were zero; `gcd_out` is 0.
- `steps`  out  WIDTH  number of subtractions performed. Present only with `GCD_STEPS_EN`.

## Operation
- FSM states: IDLE, CMP, SUB_A, SUB_B, DONE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`=1: latch A←`a_in`, B←`b_in`, clear the step count, go to CMP.
- CMP, evaluated in priority order:
  - A==0 and B==0 → DONE with result 0 and `zero_flag`=1.
  - A==0 → DONE with result B.
  - B==0 → DONE with result A.
  - A==B → DONE with result A.
  - A>B → SUB_A.
  - Otherwise → SUB_B.
- SUB_A: A←A−B, step count +1, go to CMP.
- SUB_B: B←B−A, step count +1, go to CMP.
- DONE:
  - `out_valid`=1; `gcd_out`, `zero_flag` and `steps` are held stable.
  - When `out_ready`=1: go to IDLE.
- Arithmetic:
  - Unsigned WIDTH-bit values throughout.
  - Subtraction is performed only when the minuend is strictly larger, so it never underflows.
- `in_valid` outside IDLE is ignored. Operands are not queued.
- `a_in` and `b_in` are sampled only on the accepting edge. Later changes to them have no effect.
- Registered outputs `gcd_out`, `zero_flag` and `steps` are loaded on the CMP→DONE transition and keep their values through IDLE until the next result.

## Timing
- Reset values:
  - state = IDLE, so `in_ready`=1 in the first cycle after reset.
  - `out_valid`=0, `gcd_out`=0, `zero_flag`=0, `steps`=0.
  - Internal A=0, B=0.
- Reset mid-operation returns to IDLE in one edge and discards the operation; no result is produced.
- Latency: `out_valid` rises 2·S+1 edges after the accepting edge, where S is the number of subtractions.
- Worst case: gcd(2^WIDTH−1, 1) gives S = 2^WIDTH−2. The step count therefore never exceeds WIDTH bits.
- Throughput:
  - DONE with `out_ready`=1 returns to IDLE on the next edge.
  - The minimum spacing between accepting edges is 2·S+3.
- `out_ready` already high on DONE entry still holds `out_valid` for exactly one cycle.
- Simultaneous `RST` and `in_valid`: reset wins and the operands are not latched.

## Configuration
- `GCD_STEPS_EN` defined:
  - The `steps` port and its WIDTH-bit counter exist.
  - The counter is cleared on accept, incremented in SUB_A/SUB_B, and copied to `steps` on DONE entry.
- `GCD_STEPS_EN` undefined:
  - No `steps` port and no counter.
  - All other behaviour and timing are identical.

## Structure
- Package `gcd_pkg`:
  - state typedef `gcd_state_t` with encodings IDLE=3'd0, CMP=3'd1, SUB_A=3'd2, SUB_B=3'd3, DONE=3'd4.
  - default-width constant `GCD_WIDTH_DEF`=8.
- Sub-module `gcd_datapath`:
  - holds the A/B registers, comparator (eq, gt, a_zero, b_zero) and the subtractor.
  - driven by load/sub_a/sub_b strobes from the FSM in `gcd_core`.

## Test plan
- Reset, then a=12, b=8 with `out_ready`=1 → `out_valid` 5 edges after accept, `gcd_out`=4, `zero_flag`=0, `steps`=2.
- a=0, b=9 → `gcd_out`=9 one edge after accept. Then a=0, b=0 → `gcd_out`=0, `zero_flag`=1.
- WIDTH=8, a=255, b=1 → `gcd_out`=1, `steps`=254, latency 509 edges. `in_ready`=0 throughout; `in_valid` pulses mid-run are ignored.
- a=21, b=6 with `out_ready`=0 for 10 cycles → `out_valid`=1 and `gcd_out`=3 held stable. Raising `out_ready` → IDLE next edge, `in_ready`=1.
- `RST` asserted two edges into a=100, b=75 → next cycle `in_ready`=1, `out_valid`=0. A fresh a=100, b=75 → `gcd_out`=25.
- Back-to-back: `in_valid` held high with (6,6) then (9,3) → first result 6, second 3, spacing between accepts = 2·0+3 = 3 edges.
